uart_frame_ctrl: RTL and testbench

Sequencing controller between the UART byte link and the CNN inference core. It hunts for a header byte on the `uart_rx` byte stream and writes the following `N_PIXELS` bytes into the input frame buffer. It then pulses the core's `start`, waits for `done`, and returns the predicted class as an ASCII character plus newline through `uart_tx`. An inter-byte timeout guards against truncated frames.

---
 rtl/uart_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_frame_ctrl
//
// Sequencing controller between the UART byte link and the CNN inference
// core. It hunts the received byte stream for a header byte, stores the
// following N_PIXELS payload bytes into the input frame buffer, pulses the
// core's start, waits for done, and returns the predicted class as an ASCII
// character followed by a newline through the UART transmitter. An
// inter-byte timeout abandons frames that stop arriving part-way through.
//
// Parameters
//   N_PIXELS      payload bytes per frame (>= 1)
//   ADDR_W        frame-buffer address width
//   HEADER        frame start marker byte
//   TIMEOUT_CLKS  max idle clocks between payload bytes (>= 2)
//
// Ports
//   clk        in   system clock (single domain)
//   reset      in   synchronous, active-high reset
//   rx_dv      in   one-cycle byte-valid pulse from the UART receiver
//   rx_byte    in   received byte, valid with rx_dv
//   tx_busy    in   UART transmitter busy, rises the cycle after tx_dv
//   tx_dv      out  one-cycle transmit request
//   tx_byte    out  byte to transmit, valid with tx_dv
//   fb_we      out  frame-buffer write enable (one cycle per payload byte)
//   fb_addr    out  frame-buffer write address
//   fb_wdata   out  frame-buffer write data
//   start      out  one-cycle inference start pulse
//   done       in   inference complete (pulse or level)
//   digit      in   predicted class, sampled when done is first seen
//   busy       out  high whenever the controller is not idle
//   frame_err  out  one-cycle pulse when a frame is abandoned on timeout
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module uart_frame_ctrl #(
  parameter int unsigned N_PIXELS     = 784,
  // A one-pixel frame still needs a one-bit address port.
  parameter int unsigned ADDR_W       = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              tx_busy,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              start,
  input  logic              done,
  input  logic [3:0]        digit,
  output logic              busy,
  output logic              frame_err
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  // The byte counter carries one extra bit so a power-of-two frame length
  // cannot wrap back to zero before the last byte is recognised.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PIXELS - 1);

  // The idle counter restarts at zero on every payload byte. The abort is
  // raised while it steps to TIMEOUT_CLKS-1, so frame_err appears exactly
  // TIMEOUT_CLKS cycles after the last accepted byte.
  localparam int unsigned TMO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 2);

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_QM   = 8'h3F;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  // Each transmitted byte is acknowledged in two steps: first wait for the
  // transmitter to report busy (it takes one cycle to react), then wait for
  // it to go idle again. This keeps tx_dv from ever firing back to back.
  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_LOAD        = 4'd1;
  localparam logic [3:0] S_START       = 4'd2;
  localparam logic [3:0] S_WAIT_DONE   = 4'd3;
  localparam logic [3:0] S_TX_CHAR     = 4'd4;
  localparam logic [3:0] S_ACK_CHAR_HI = 4'd5;
  localparam logic [3:0] S_ACK_CHAR_LO = 4'd6;
  localparam logic [3:0] S_TX_NL       = 4'd7;
  localparam logic [3:0] S_ACK_NL_HI   = 4'd8;
  localparam logic [3:0] S_ACK_NL_LO   = 4'd9;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [3:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [TMO_W-1:0]  tmo_q,       tmo_d;
  logic [7:0]        char_q,      char_d;

  logic              tx_dv_q,     tx_dv_d;
  logic [7:0]        tx_byte_q,   tx_byte_d;
  logic              fb_we_q,     fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q,   fb_addr_d;
  logic [7:0]        fb_wdata_q,  fb_wdata_d;
  logic              start_q,     start_d;
  logic              busy_q,      busy_d;
  logic              frame_err_q, frame_err_d;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d signal is given a default before the case statement so
    // no path through the decoder leaves a value unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    char_d      = char_q;
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    start_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Anything other than the header is discarded while hunting.
        if (rx_dv && (rx_byte == HEADER)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end

      S_LOAD: begin
        // Inside the payload every byte is data, including HEADER values.
        if (rx_dv) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = cnt_q[ADDR_W-1:0];
          fb_wdata_d = rx_byte;
          tmo_d      = '0;
          if (cnt_q == CNT_LAST) begin
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // A byte arriving in this same cycle takes the branch above
          // instead, so a late but in-time byte is never lost.
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // The class is captured on the first done cycle; a level-style done
        // that stays high is not looked at again until the next frame.
        if (done) begin
          char_d  = (digit <= 4'd9) ? (ASCII_ZERO + {4'h0, digit}) : ASCII_QM;
          state_d = S_TX_CHAR;
        end
      end

      S_TX_CHAR: begin
        if (!tx_busy) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = char_q;
          state_d   = S_ACK_CHAR_HI;
        end
      end

      S_ACK_CHAR_HI: if (tx_busy)  state_d = S_ACK_CHAR_LO;
      S_ACK_CHAR_LO: if (!tx_busy) state_d = S_TX_NL;

      S_TX_NL: begin
        if (!tx_busy) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = ASCII_LF;
          state_d   = S_ACK_NL_HI;
        end
      end

      S_ACK_NL_HI: if (tx_busy)  state_d = S_ACK_NL_LO;
      S_ACK_NL_LO: if (!tx_busy) state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // busy is registered from the next state so it tracks the state register
    // without an extra cycle of lag.
    busy_d = (state_d != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      char_q      <= '0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      char_q      <= char_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign tx_dv     = tx_dv_q;
  assign tx_byte   = tx_byte_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

  // -------------------------------------------------------------------------
  // Interface properties
  // -------------------------------------------------------------------------
  a_addr_in_range : assert property (@(posedge clk) disable iff (reset)
    fb_we |-> ({1'b0, fb_addr} <= CNT_LAST));

  a_tx_dv_spaced : assert property (@(posedge clk) disable iff (reset)
    tx_dv |=> !tx_dv);

  a_start_single : assert property (@(posedge clk) disable iff (reset)
    start |=> !start);

  a_err_drops_busy : assert property (@(posedge clk) disable iff (reset)
    frame_err |-> !busy);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_ctrl
//
// Directed bench for uart_frame_ctrl (784-byte frames, 100-clock timeout).
// A procedural reference model follows the frame protocol as a sequence of
// waits (hunt header, collect payload, start, await done, send two bytes)
// and publishes the outputs the controller must show in the next cycle. A
// single compare process checks the DUT against it on every negative edge
// and also logs writes, starts, errors and transmitted bytes so the
// stimulus thread can pin a few hand-computed facts per scenario.
// ---------------------------------------------------------------------------
module tb_uart_frame_ctrl;

  localparam int         NPIX = 784;
  localparam int         TMO  = 100;
  localparam logic [7:0] HDR  = 8'hA5;

  // DUT signals
  logic       clk, reset;
  logic       rx_dv, tx_busy, done;
  logic [7:0] rx_byte;
  logic [3:0] digit;
  logic       tx_dv, fb_we, start, busy, frame_err;
  logic [7:0] tx_byte, fb_wdata;
  logic [9:0] fb_addr;

  uart_frame_ctrl #(
    .N_PIXELS    (NPIX),
    .HEADER      (HDR),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_dv    (rx_dv),
    .rx_byte  (rx_byte),
    .tx_busy  (tx_busy),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .start    (start),
    .done     (done),
    .digit    (digit),
    .busy     (busy),
    .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle number, advanced on every rising edge.
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [30:0] out_vec();
    return {tx_dv, tx_byte, fb_we, fb_addr, fb_wdata, start, busy, frame_err};
  endfunction

  // -------------------------------------------------------------------------
  // UART transmitter stand-in: busy for four cycles starting the cycle after
  // a request, or held high while force_busy is set.
  // -------------------------------------------------------------------------
  bit force_busy = 0;
  initial begin
    int   busy_left;
    logic prev_dv;
    busy_left = 0;
    prev_dv   = 1'b0;
    tx_busy   = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_dv === 1'b1) busy_left = 4;
      else if (busy_left > 0) busy_left--;
      tx_busy = force_busy || (busy_left > 0);
      prev_dv = tx_dv;
    end
  end

  // -------------------------------------------------------------------------
  // Reference model. Each step() consumes one rising edge and describes the
  // outputs that must be visible during the following cycle.
  // -------------------------------------------------------------------------
  logic       exp_fb_we, exp_start, exp_tx_dv, exp_frame_err, exp_busy;
  logic [9:0] exp_addr;
  logic [7:0] exp_wdata, exp_tx_byte;
  bit         m_abort;

  initial begin
    exp_fb_we = 0; exp_start = 0; exp_tx_dv = 0; exp_frame_err = 0; exp_busy = 0;
    exp_addr = '0; exp_wdata = '0; exp_tx_byte = '0;
  end

  task automatic step();
    @(posedge clk);
    exp_fb_we     = 1'b0;
    exp_start     = 1'b0;
    exp_tx_dv     = 1'b0;
    exp_frame_err = 1'b0;
    if (reset === 1'b1) begin
      m_abort     = 1'b1;
      exp_busy    = 1'b0;
      exp_addr    = '0;
      exp_wdata   = '0;
      exp_tx_byte = '0;
    end
  endtask

  // Send one byte once the transmitter is free, then see it go busy and idle.
  task automatic m_send(input logic [7:0] b, input bit last);
    while (1) begin
      step(); if (m_abort) return;
      if (!tx_busy) begin exp_tx_dv = 1'b1; exp_tx_byte = b; break; end
    end
    while (1) begin step(); if (m_abort) return; if (tx_busy)  break; end
    while (1) begin step(); if (m_abort) return; if (!tx_busy) break; end
    if (last) exp_busy = 1'b0;
  endtask

  initial begin : ref_model
    int got, quiet;
    logic [7:0] ch;
    forever begin
      m_abort = 1'b0;
      // Hunt for the header; everything else is ignored.
      while (1) begin
        step(); if (m_abort) break;
        if (rx_dv === 1'b1 && rx_byte == HDR) break;
      end
      if (m_abort) continue;
      exp_busy = 1'b1;
      // Payload: every valid byte is written in arrival order; TMO quiet
      // cycles after the last activity abandon the frame.
      got = 0; quiet = 0;
      while (got < NPIX) begin
        step(); if (m_abort) break;
        if (rx_dv === 1'b1) begin
          exp_fb_we = 1'b1; exp_addr = 10'(got); exp_wdata = rx_byte;
          got++; quiet = 0;
        end else begin
          quiet++;
          if (quiet == TMO - 1) begin exp_frame_err = 1'b1; exp_busy = 1'b0; break; end
        end
      end
      if (m_abort || got < NPIX) continue;
      step(); if (m_abort) continue;
      exp_start = 1'b1;
      // Any done from here on counts, beginning with the start cycle itself.
      while (1) begin step(); if (m_abort) break; if (done === 1'b1) break; end
      if (m_abort) continue;
      ch = (digit <= 4'd9) ? 8'h30 + 8'(digit) : 8'h3F;
      m_send(ch, 1'b0);
      if (m_abort) continue;
      m_send(8'h0A, 1'b1);
    end
  end

  // -------------------------------------------------------------------------
  // Compare process and event log.
  // -------------------------------------------------------------------------
  logic [9:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];
  logic [7:0] tx_log[$];
  int         tx_cyc_log[$];
  int         start_cnt = 0, start_cyc = 0, err_cnt = 0, err_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("ctrl{we,start,tx_dv,err,busy}",
            32'({fb_we, start, tx_dv, frame_err, busy}),
            32'({exp_fb_we, exp_start, exp_tx_dv, exp_frame_err, exp_busy}));
      if (exp_fb_we) check("fb_addr_data", 32'({fb_addr, fb_wdata}), 32'({exp_addr, exp_wdata}));
      if (exp_tx_dv) check("tx_byte", 32'(tx_byte), 32'(exp_tx_byte));
      if (fb_we === 1'b1) begin wr_addr_log.push_back(fb_addr); wr_data_log.push_back(fb_wdata); end
      if (start === 1'b1) begin start_cnt++; start_cyc = cyc; end
      if (frame_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (tx_dv === 1'b1) begin tx_log.push_back(tx_byte); tx_cyc_log.push_back(cyc); end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge).
  // -------------------------------------------------------------------------
  int last_rx_cyc = 0;

  task automatic send_byte(input logic [7:0] b, input int idle);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = b; last_rx_cyc = cyc;
    @(negedge clk);
    rx_dv = 1'b0; rx_byte = HDR;  // header value on an invalid cycle must be ignored
    repeat (idle) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] first, input bit gappy);
    send_byte(HDR, 0);
    for (int i = 0; i < NPIX; i++) send_byte(first + 8'(i), gappy ? (i % 3) : 0);
  endtask

  task automatic pulse_done(input logic [3:0] d);
    @(negedge clk);
    done = 1'b1; digit = d;
    @(negedge clk);
    done = 1'b0; digit = ~d;
  endtask

  task automatic wait_start(input string nm, input int base);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (start_cnt > base) begin ok = 1; break; end
      @(negedge clk);
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1; break; end
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  initial begin
    int wb, sb, tb0, eb, rel;
    reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; done = 1'b0; digit = 4'h0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset_outputs", 32'(out_vec()), 32'd0);

    // 1: full frame, bytes 0..255 repeating, class 7.
    wb = wr_addr_log.size(); sb = start_cnt; tb0 = tx_log.size();
    send_frame(8'h00, 1'b0);
    wait_start("t1_start_seen", sb);
    check("t1_start_latency", 32'(start_cyc - last_rx_cyc), 32'd2);
    repeat (3) @(negedge clk);
    pulse_done(4'd7);
    wait_idle("t1_idle_reached");
    check("t1_write_count", 32'(wr_addr_log.size() - wb), 32'd784);
    check("t1_first_write", 32'({wr_addr_log[wb], wr_data_log[wb]}), 32'({10'd0, 8'h00}));
    check("t1_last_write",  32'({wr_addr_log[wb+783], wr_data_log[wb+783]}), 32'({10'd783, 8'h0F}));
    check("t1_start_count", 32'(start_cnt - sb), 32'd1);
    check("t1_tx_count", 32'(tx_log.size() - tb0), 32'd2);
    check("t1_tx_bytes", 32'({tx_log[tb0], tx_log[tb0+1]}), 32'h370A);
    check("t1_busy_low", 32'(busy), 32'd0);

    // 2: garbage before the header, irregular byte spacing, class 0.
    wb = wr_addr_log.size(); tb0 = tx_log.size();
    send_byte(8'h00, 2);
    send_byte(8'h55, 2);
    check("t2_no_garbage_writes", 32'(wr_addr_log.size() - wb), 32'd0);
    sb = start_cnt;
    send_frame(8'h10, 1'b1);
    wait_start("t2_start_seen", sb);
    pulse_done(4'd0);
    wait_idle("t2_idle_reached");
    check("t2_first_write", 32'({wr_addr_log[wb], wr_data_log[wb]}), 32'({10'd0, 8'h10}));
    check("t2_write_count", 32'(wr_addr_log.size() - wb), 32'd784);
    check("t2_tx_bytes", 32'({tx_log[tb0], tx_log[tb0+1]}), 32'h300A);

    // 3: truncated frame times out, then a clean frame (class 9) follows.
    wb = wr_addr_log.size(); sb = start_cnt; eb = err_cnt;
    send_byte(HDR, 0);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 1), 0);
    repeat (110) @(negedge clk);
    check("t3_err_count", 32'(err_cnt - eb), 32'd1);
    check("t3_err_latency", 32'(err_cyc - last_rx_cyc), 32'd100);
    check("t3_no_start", 32'(start_cnt - sb), 32'd0);
    check("t3_partial_writes", 32'(wr_addr_log.size() - wb), 32'd10);
    check("t3_busy_low", 32'(busy), 32'd0);
    tb0 = tx_log.size();
    send_frame(8'h33, 1'b0);
    wait_start("t3_start_seen", sb);
    pulse_done(4'd9);
    wait_idle("t3_idle_reached");
    check("t3_tx_bytes", 32'({tx_log[tb0], tx_log[tb0+1]}), 32'h390A);

    // 4: out-of-range class with the transmitter held busy for 50 cycles.
    sb = start_cnt; tb0 = tx_log.size();
    send_frame(8'hC0, 1'b0);
    wait_start("t4_start_seen", sb);
    force_busy = 1'b1;
    pulse_done(4'd12);
    repeat (48) @(negedge clk);
    check("t4_no_tx_while_held", 32'(tx_log.size() - tb0), 32'd0);
    force_busy = 1'b0;
    rel = cyc;
    wait_idle("t4_idle_reached");
    check("t4_tx_count", 32'(tx_log.size() - tb0), 32'd2);
    check("t4_tx_bytes", 32'({tx_log[tb0], tx_log[tb0+1]}), 32'h3F0A);
    check("t4_tx_after_release", 32'(tx_cyc_log[tb0] > rel), 32'd1);

    // 5: stray bytes and done pulses after start.
    wb = wr_addr_log.size(); sb = start_cnt; tb0 = tx_log.size();
    send_frame(8'h80, 1'b0);
    wait_start("t5_start_seen", sb);
    send_byte(HDR, 0);
    send_byte(8'h12, 0);
    pulse_done(4'd3);
    send_byte(8'h34, 0);
    pulse_done(4'd9);
    send_byte(8'h56, 0);
    pulse_done(4'd1);
    wait_idle("t5_idle_reached");
    check("t5_write_count", 32'(wr_addr_log.size() - wb), 32'd784);
    check("t5_start_count", 32'(start_cnt - sb), 32'd1);
    check("t5_tx_count", 32'(tx_log.size() - tb0), 32'd2);
    check("t5_tx_bytes", 32'({tx_log[tb0], tx_log[tb0+1]}), 32'h330A);

    // 6: reset after 300 payload bytes, then a fresh frame (class 5).
    sb = start_cnt;
    send_byte(HDR, 0);
    for (int i = 0; i < 300; i++) send_byte(8'(i * 7), 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("t6_reset_outputs", 32'(out_vec()), 32'd0);
    repeat (5) @(negedge clk);
    check("t6_no_start", 32'(start_cnt - sb), 32'd0);
    wb = wr_addr_log.size(); tb0 = tx_log.size();
    send_frame(8'h40, 1'b0);
    wait_start("t6_start_seen", sb);
    pulse_done(4'd5);
    wait_idle("t6_idle_reached");
    check("t6_first_write", 32'({wr_addr_log[wb], wr_data_log[wb]}), 32'({10'd0, 8'h40}));
    check("t6_write_count", 32'(wr_addr_log.size() - wb), 32'd784);
    check("t6_tx_bytes", 32'({tx_log[tb0], tx_log[tb0+1]}), 32'h350A);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
